// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state encoding and digit helpers for the decade cascade.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_reg.sv
// One enabled BCD digit register: counts 0..MAX on inc_i, pulses wrap_o for one
// cycle on the MAX->0 roll. Reusable for further decades of the cascade.
module bcd_digit_reg
  import bcd_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = BCD_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             wrap_o
);

  logic [BCD_W-1:0] digit_q, digit_d;
  logic             wrap_q, wrap_d;

  // Next digit and roll-over pulse; the pulse lasts one cycle by default-clearing.
  always_comb begin
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (inc_i) begin
      if (digit_q >= MAX) begin
        digit_d = '0;
        wrap_d  = 1'b1;
      end else begin
        digit_d = digit_q + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      digit_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digit_o = digit_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/bcd_tens_cascade.sv
// Tens stage behind a mod-10 units counter: registers units, detects 9->0 and
// advances the tens digit. Optional invalid-code fault tracking: BCD_INVALID_CHECK_EN.
module bcd_tens_cascade
  import bcd_pkg::*;
#(
  parameter int unsigned TENS_MAX = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] units,
  input  logic             en,
  output logic [BCD_W-1:0] tens,
  output logic [7:0]       count,
  output logic             carry,
  output logic             err
);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] units_q;
  logic             primed_q;
  logic             wrap_c;
  logic             is_wrap_c;

  // units_q only holds a trustworthy previous sample once a RUN edge has loaded it.
  assign is_wrap_c = primed_q && en && (units_q == BCD_MAX) && (units == '0);

  always_comb begin
    state_d = state_q;
    wrap_c  = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
`ifdef BCD_INVALID_CHECK_EN
        if (!is_bcd(units)) begin
          state_d = ST_FAULT;
        end else begin
          wrap_c = is_wrap_c;
        end
`else
        wrap_c = is_wrap_c;
`endif
      end
      ST_FAULT: begin
        // Recovery edge re-synchronises on a 0 sample but is not itself a wrap.
        if (units == '0) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      units_q  <= '0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      units_q  <= units;
      primed_q <= primed_q || (state_q == ST_RUN);
    end
  end

  bcd_digit_reg #(
    .MAX (BCD_W'(TENS_MAX))
  ) u_tens (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (wrap_c),
    .digit_o (tens),
    .wrap_o  (carry)
  );

  assign count = {tens, units_q};

`ifdef BCD_INVALID_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_d == ST_FAULT);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_tens_cascade.sv
// Self-checking bench: mod-100 and mod-60 cascades driven in parallel against a
// cycle-level arithmetic model of the two-digit count.
module tb_bcd_tens_cascade;

  logic       clk;
  logic       rst;
  logic [3:0] units;
  logic       en;
  logic [3:0] tens9, tens5;
  logic [7:0] count9, count5;
  logic       carry9, carry5;
  logic       err9, err5;

  int checks;
  int failures;

  // Reference model state
  int mt[2];
  int mc[2];
  int maxv[2];
  int muq;
  int nedge;
  bit mfault;

  bcd_tens_cascade #(.TENS_MAX(9)) dut9 (
    .clk(clk), .rst(rst), .units(units), .en(en),
    .tens(tens9), .count(count9), .carry(carry9), .err(err9)
  );

  bcd_tens_cascade #(.TENS_MAX(5)) dut5 (
    .clk(clk), .rst(rst), .units(units), .en(en),
    .tens(tens5), .count(count5), .carry(carry5), .err(err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_count(input int k);
    return 8'(mt[k] * 16 + muq);
  endfunction

  // Drive one cycle and advance the model by the same edge
  task automatic cyc(input bit rr, input bit ee, input int uu);
    bit w;
    rst   = rr;
    en    = ee;
    units = 4'(uu);
    @(posedge clk);
    if (!rr) begin
      for (int k = 0; k < 2; k++) begin
        mt[k] = 0;
        mc[k] = 0;
      end
      muq    = 0;
      nedge  = 0;
      mfault = 1'b0;
    end else begin
      w = (nedge >= 2) && !mfault && (muq == 9) && (uu == 0) && ee;
      for (int k = 0; k < 2; k++) begin
        if (w) begin
          if (mt[k] == maxv[k]) begin
            mt[k] = 0;
            mc[k] = 1;
          end else begin
            mt[k] = mt[k] + 1;
            mc[k] = 0;
          end
        end else begin
          mc[k] = 0;
        end
      end
`ifdef BCD_INVALID_CHECK_EN
      if (mfault) begin
        if (uu == 0) mfault = 1'b0;
      end else if (nedge >= 1 && uu > 9) begin
        mfault = 1'b1;
      end
`endif
      muq = uu;
      if (nedge < 3) nedge = nedge + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 1, 9);
    cyc(0, 1, 0);
    checks++; if (count9 !== 8'h00) begin failures++; $display("FAIL reset_count9 got=%h exp=00", count9); end
    checks++; if (carry9 !== 1'b0) begin failures++; $display("FAIL reset_carry9 got=%b exp=0", carry9); end
    checks++; if (err9 !== 1'b0) begin failures++; $display("FAIL reset_err9 got=%b exp=0", err9); end
    checks++; if (count5 !== 8'h00) begin failures++; $display("FAIL reset_count5 got=%h exp=00", count5); end
  endtask

  task automatic test_count();
    int p9, p5;
    cyc(0, 1, 0);
    for (int i = 0; i < 120; i++) begin
      cyc(1, 1, i % 10);
      checks++; if (count9 !== exp_count(0)) begin failures++; $display("FAIL count9 cyc=%0d got=%h exp=%h", i, count9, exp_count(0)); end
      checks++; if (carry9 !== 1'(mc[0])) begin failures++; $display("FAIL carry9 cyc=%0d got=%b exp=%0d", i, carry9, mc[0]); end
      checks++; if (count5 !== exp_count(1)) begin failures++; $display("FAIL count5 cyc=%0d got=%h exp=%h", i, count5, exp_count(1)); end
      checks++; if (carry5 !== 1'(mc[1])) begin failures++; $display("FAIL carry5 cyc=%0d got=%b exp=%0d", i, carry5, mc[1]); end
    end
    p9 = 0;
    p5 = 0;
    for (int i = 120; i < 420; i++) begin
      cyc(1, 1, i % 10);
      if (carry9 === 1'b1) p9++;
      if (carry5 === 1'b1) p5++;
      if (carry9 === 1'b1) begin
        checks++; if (count9 !== 8'h00) begin failures++; $display("FAIL carry9_at_00 got=%h exp=00", count9); end
      end
      if (carry5 === 1'b1) begin
        checks++; if (count5 !== 8'h00) begin failures++; $display("FAIL carry5_at_00 got=%h exp=00", count5); end
      end
    end
    checks++; if (p9 != 3) begin failures++; $display("FAIL carry9_rate got=%0d exp=3", p9); end
    checks++; if (p5 != 5) begin failures++; $display("FAIL carry5_rate got=%0d exp=5", p5); end
  endtask

  task automatic test_enable();
    int t0;
    for (int i = 0; i < 20 && muq != 8; i++) cyc(1, 1, (muq + 1) % 10);
    checks++; if (muq != 8) begin failures++; $display("FAIL enable_setup got=%0d exp=8", muq); end
    t0 = mt[0];
    cyc(1, 1, 9);
    cyc(1, 0, 0);
    checks++; if (tens9 !== 4'(t0)) begin failures++; $display("FAIL en0_lost got=%0d exp=%0d", tens9, t0); end
    checks++; if (carry9 !== 1'b0) begin failures++; $display("FAIL en0_carry got=%b exp=0", carry9); end
    for (int v = 1; v <= 9; v++) cyc(1, 1, v);
    checks++; if (tens9 !== 4'(t0)) begin failures++; $display("FAIL en1_hold got=%0d exp=%0d", tens9, t0); end
    cyc(1, 1, 0);
    checks++; if (tens9 !== 4'((t0 + 1) % 10)) begin failures++; $display("FAIL en1_wrap got=%0d exp=%0d", tens9, (t0 + 1) % 10); end
  endtask

  task automatic test_jumps();
    int seq[8] = '{3, 4, 5, 0, 1, 9, 9, 9};
    int t0;
    t0 = mt[0];
    foreach (seq[i]) begin
      cyc(1, 1, seq[i]);
      checks++; if (tens9 !== 4'(t0)) begin failures++; $display("FAIL jump_tens step=%0d got=%0d exp=%0d", i, tens9, t0); end
      checks++; if (carry9 !== 1'b0) begin failures++; $display("FAIL jump_carry step=%0d got=%b exp=0", i, carry9); end
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 0);
    for (int i = 0; i < 200 && !(mt[0] == 7 && muq == 9); i++) cyc(1, 1, (muq + 1) % 10);
    checks++; if (count9 !== 8'h79) begin failures++; $display("FAIL mid_setup got=%h exp=79", count9); end
    cyc(0, 1, 0);
    checks++; if (count9 !== 8'h00) begin failures++; $display("FAIL mid_count got=%h exp=00", count9); end
    checks++; if (tens9 !== 4'd0) begin failures++; $display("FAIL mid_tens got=%0d exp=0", tens9); end
    checks++; if (carry9 !== 1'b0) begin failures++; $display("FAIL mid_carry got=%b exp=0", carry9); end
    checks++; if (count5 !== 8'h00) begin failures++; $display("FAIL mid_count5 got=%h exp=00", count5); end
  endtask

  task automatic test_random();
    bit rr, ee;
    int uu;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 59) != 0);
      ee = ($urandom_range(0, 5) != 0);
      uu = ($urandom_range(0, 9) < 8) ? (muq + 1) % 10 : int'($urandom_range(0, 15));
      cyc(rr, ee, uu);
      checks++; if (count9 !== exp_count(0)) begin failures++; $display("FAIL rnd_count9 i=%0d got=%h exp=%h", i, count9, exp_count(0)); end
      checks++; if (carry9 !== 1'(mc[0])) begin failures++; $display("FAIL rnd_carry9 i=%0d got=%b exp=%0d", i, carry9, mc[0]); end
      checks++; if (count5 !== exp_count(1)) begin failures++; $display("FAIL rnd_count5 i=%0d got=%h exp=%h", i, count5, exp_count(1)); end
      checks++; if (carry5 !== 1'(mc[1])) begin failures++; $display("FAIL rnd_carry5 i=%0d got=%b exp=%0d", i, carry5, mc[1]); end
      checks++; if (err9 !== mfault) begin failures++; $display("FAIL rnd_err9 i=%0d got=%b exp=%b", i, err9, mfault); end
    end
  endtask

  task automatic test_invalid();
    cyc(0, 1, 0);
    for (int i = 0; i < 100 && !(mt[0] == 3 && muq == 4); i++) cyc(1, 1, (muq + 1) % 10);
    checks++; if (count9 !== 8'h34) begin failures++; $display("FAIL inv_setup got=%h exp=34", count9); end
    cyc(1, 1, 12);
`ifdef BCD_INVALID_CHECK_EN
    checks++; if (err9 !== 1'b1) begin failures++; $display("FAIL inv_err got=%b exp=1", err9); end
    checks++; if (tens9 !== 4'd3) begin failures++; $display("FAIL inv_tens got=%0d exp=3", tens9); end
    cyc(1, 1, 9);
    checks++; if (err9 !== 1'b1) begin failures++; $display("FAIL inv_hold_err got=%b exp=1", err9); end
    cyc(1, 1, 0);
    checks++; if (err9 !== 1'b0) begin failures++; $display("FAIL inv_recover_err got=%b exp=0", err9); end
    checks++; if (tens9 !== 4'd3) begin failures++; $display("FAIL inv_recover_tens got=%0d exp=3", tens9); end
`else
    checks++; if (err9 !== 1'b0) begin failures++; $display("FAIL inv_err got=%b exp=0", err9); end
    checks++; if (count9 !== 8'h3C) begin failures++; $display("FAIL inv_units_q got=%h exp=3c", count9); end
    cyc(1, 1, 0);
    checks++; if (tens9 !== 4'd3) begin failures++; $display("FAIL inv_nowrap got=%0d exp=3", tens9); end
`endif
    for (int v = 1; v <= 9; v++) cyc(1, 1, v);
    cyc(1, 1, 0);
    checks++; if (tens9 !== 4'd4) begin failures++; $display("FAIL inv_resume got=%0d exp=4", tens9); end
    checks++; if (err9 !== 1'b0) begin failures++; $display("FAIL inv_resume_err got=%b exp=0", err9); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    maxv[0]  = 9;
    maxv[1]  = 5;
    rst      = 1'b0;
    en       = 1'b0;
    units    = 4'd0;
    muq      = 0;
    nedge    = 0;
    mfault   = 1'b0;
    test_reset();
    test_count();
    test_enable();
    test_jumps();
    test_reset_mid();
    test_random();
    test_invalid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_tens_cascade.md
# bcd_tens_cascade

Downstream stage for the 4-bit mod-10 (BCD units) counter. It samples the units digit every clock, detects the 9→0 wrap, and advances a registered tens digit, producing a two-digit BCD count (00–99 by default) plus a one-cycle carry at full wrap. It extends a single decade counter into a cascaded decade chain without modifying the upstream counter.

## Interface
- TENS_MAX, default 9: last tens value before tens wraps to 0. Legal range 1–9. Default gives mod-100.
- clk  input  1  rising-edge clock, shared with the units counter.
- rst  input  1  synchronous, active-low reset.
- units  input  4  BCD units digit from the mod-10 counter, sampled on every rising edge.
- en  input  1  wrap-detection enable.
- tens  output  4  registered tens digit, 0..TENS_MAX.
- count  output  8  {tens, units_q}. units_q is the registered copy of units.
- carry  output  1  one-cycle pulse when tens wraps TENS_MAX→0.
- err  output  1  invalid-code flag. Present only with the macro; otherwise tied 0.

## Operation
- Reset (rst=0 at a rising edge) sets:
  - tens=0, units_q=0, carry=0, err=0.
  - FSM state INIT.
- Reset wins over every other event in the same cycle.
- units_q <= units on every non-reset edge, regardless of en.
- wrap = (units_q==9) && (units==0) && en && (state==RUN).
- On wrap:
  - tens < TENS_MAX: tens <= tens+1, carry <= 0.
  - tens == TENS_MAX: tens <= 0, carry <= 1.
- Otherwise tens holds and carry <= 0.
- FSM states:
  - INIT: the first sample after reset has no valid previous value, so wrap detection is suppressed. Unconditionally → RUN on the next edge.
  - RUN: normal counting. With the macro, an invalid units code (10–15) → FAULT.
  - FAULT (macro only): tens frozen, err=1. Return to RUN on the edge where units==0 is sampled; that edge itself is not a wrap.
- A non-9→0 transition never increments tens (e.g. 5→0 from an upstream reset). This includes every other jump and a held 9.
- A 9→0 transition while en=0 is lost. It is not deferred.
- Arithmetic: 4-bit unsigned. tens never exceeds TENS_MAX. count is always valid BCD in RUN.

## Timing
- Latency: tens and units_q update on the same edge. count is coherent and lags units by exactly one cycle.
- carry is high in the same cycle count first reads {0,0}, and for that one cycle only.
- Upstream counting every cycle (0..9 repeating): tens increments once every 10 cycles. carry pulses once every 10×(TENS_MAX+1) cycles.
- First possible wrap detection is the third rising edge after rst deasserts:
  - edge 1: INIT
  - edge 2: RUN, units_q loaded
  - edge 3: first wrap check
- Reset asserted mid-count: the next edge clears all outputs, independent of en, units and state.

## Configuration
- BCD_INVALID_CHECK_EN defined:
  - Sampled units 10–15 in RUN → FAULT, err=1, tens frozen.
  - units_q still tracks the input.
  - Recovery is described under Operation.
- Not defined:
  - No FAULT state, err tied 0.
  - Invalid codes are registered into units_q but cannot form a wrap, since 9→0 is the only trigger.

## Structure
- Shared package bcd_pkg holds:
  - BCD digit width constant (4).
  - BCD_MAX constant (9).
  - FSM state encoding: INIT, RUN, FAULT, 2-bit.
- One natural sub-module, bcd_digit_reg: a single enabled BCD digit register with a programmable max and a wrap pulse. It is instantiated for tens and is reusable for further decades.
- Top level holds the units_q register, wrap detect and FSM.

## Test plan
- Reset, then 0..9 repeating every cycle, en=1 → tens increments once per 10 cycles. After 100 units steps count=0x00 and carry pulses exactly once, in the cycle count returns to 0x00.
- Counting with en=0 for one full 9→0 transition → tens unchanged. Re-enabled, the next wrap increments tens by exactly 1.
- units sequence 3,4,5,0,1 (upstream reset, no 9) → tens unchanged, carry=0.
- rst=0 asserted while count=0x79 and units=0 (a wrap condition) → next edge gives tens=0, count=0x00, carry=0.
- TENS_MAX=5, continuous counting → count cycles 00..59. carry pulses every 60 cycles when count goes 59→00.
- With BCD_INVALID_CHECK_EN, inject units=12 at count=0x34 → err=1 and tens held at 3. Feed 0 → err=0, RUN, tens still 3. Then 1..9,0 → tens=4.
